// File: rtl/nn_weight_update_seq_if.sv
// Update / load / read / status bus of the weight-update sequencer.
// The slave modport is the sequencer side; the master modport is the requester side.
interface nn_weight_update_seq_if #(
  parameter int Nbase = 8,
  parameter int Narg  = 16,
  parameter int IDXW  = 4
);
  logic              upd_valid;
  logic              upd_ready;
  logic [IDXW-1:0]   upd_idx;
  logic [Narg-1:0]   upd_arg;
  logic [7:0]        upd_rate;
  logic              upd_op;
  logic              ld_en;
  logic [IDXW-1:0]   ld_idx;
  logic [Nbase-1:0]  ld_data;
  logic [IDXW-1:0]   rd_idx;
  logic [Nbase-1:0]  rd_data;
  logic              upd_done;
  logic [IDXW-1:0]   upd_done_idx;
  logic              upd_sat;
  logic [15:0]       sat_count;

  modport slave (
    input  upd_valid, upd_idx, upd_arg, upd_rate, upd_op,
    input  ld_en, ld_idx, ld_data, rd_idx,
    output upd_ready, rd_data, upd_done, upd_done_idx, upd_sat, sat_count
  );

  modport master (
    output upd_valid, upd_idx, upd_arg, upd_rate, upd_op,
    output ld_en, ld_idx, ld_data, rd_idx,
    input  upd_ready, rd_data, upd_done, upd_done_idx, upd_sat, sat_count
  );
endinterface

// File: rtl/nn_weight_update_seq.sv
// Bank of NW unsigned weights updated by rate-scaled saturating add/subtract.
// One request per cycle: accepted into a stage register, written back at the next edge.
module nn_weight_update_seq #(
  parameter int Nbase = 8,
  parameter int Narg  = 16,
  parameter int NW    = 16,
  parameter int IDXW  = (NW > 1) ? $clog2(NW) : 1,
  parameter logic [Nbase-1:0] INIT_VAL = {1'b1, {(Nbase-1){1'b0}}}
) (
  input  logic CLK,
  input  logic RST,
  nn_weight_update_seq_if.slave bus
);

  // Scaled argument is compared at the wider of the two widths so the clamp works either way round.
  localparam int SW = (Narg > Nbase) ? Narg : Nbase;
  localparam logic [SW-1:0] MAXS = SW'({Nbase{1'b1}});

  logic [Nbase-1:0] bank [NW];

  logic             rdy_q;
  logic             upd_ready;

  logic             vld_p0;
  logic [IDXW-1:0]  idx_p0;
  logic [Narg-1:0]  arg_p0;
  logic [7:0]       rate_p0;
  logic             op_p0;

  logic             done_p1;
  logic [IDXW-1:0]  done_idx_p1;
  logic             sat_p1;
  logic [15:0]      sat_cnt_p1;
  logic [Nbase-1:0] rd_p1;

  logic             upd_ok;
  logic             ld_ok;
  logic             rd_ok;
  logic             ld_hit;
  logic             wb_en;
  logic             wb_sat;
  logic [Nbase-1:0] w_cur;
  logic [Nbase:0]   sc_s;
  logic [Nbase:0]   res_s;

  // Right-shift by rate, then clamp to the weight range; MSB of the result flags the clamp.
  function automatic logic [Nbase:0] scale_clamp(input logic [Narg-1:0] arg,
                                                 input logic [7:0] rate);
    logic [SW-1:0] sc;
    sc = (int'(rate) >= Narg) ? '0 : SW'(arg >> rate);
    if (sc > MAXS) return {1'b1, {Nbase{1'b1}}};
    return {1'b0, sc[Nbase-1:0]};
  endfunction

  // Saturating add (op=0) or subtract (op=1); MSB of the result flags a clamp.
  function automatic logic [Nbase:0] addsub_sat(input logic [Nbase-1:0] w,
                                                input logic [Nbase-1:0] s,
                                                input logic op);
    logic [Nbase:0] sum;
    if (!op) begin
      sum = {1'b0, w} + {1'b0, s};
      if (sum[Nbase]) return {1'b1, {Nbase{1'b1}}};
      return sum;
    end
    if (s > w) return {1'b1, {Nbase{1'b0}}};
    return {1'b0, w - s};
  endfunction

  // A load in the same cycle blocks acceptance so the requester sees a clean stall.
  assign upd_ready        = rdy_q & ~bus.ld_en;
  assign bus.upd_ready    = upd_ready;
  assign bus.rd_data      = rd_p1;
  assign bus.upd_done     = done_p1;
  assign bus.upd_done_idx = done_idx_p1;
  assign bus.upd_sat      = sat_p1;
  assign bus.sat_count    = sat_cnt_p1;

  // Stage 2: compute the new weight from the stage register and the live bank contents.
  always_comb begin
    upd_ok = vld_p0 && (int'(idx_p0) < NW);
    ld_ok  = bus.ld_en && (int'(bus.ld_idx) < NW);
    rd_ok  = int'(bus.rd_idx) < NW;
    w_cur  = upd_ok ? bank[idx_p0] : '0;
    sc_s   = scale_clamp(arg_p0, rate_p0);
    res_s  = addsub_sat(w_cur, sc_s[Nbase-1:0], op_p0);
    ld_hit = ld_ok && upd_ok && (bus.ld_idx == idx_p0);
    wb_en  = upd_ok && !ld_hit;
    wb_sat = wb_en && (sc_s[Nbase] | res_s[Nbase]);
  end

  // ---- stage 0 -> 1: acceptance control (ready and stage valid) ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdy_q  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      vld_p0 <= bus.upd_valid && upd_ready;
    end
  end

  // Capture the request payload on acceptance; payload needs no reset since vld_p0 qualifies it.
  always_ff @(posedge CLK) begin
    if (bus.upd_valid && upd_ready) begin
      idx_p0  <= bus.upd_idx;
      arg_p0  <= bus.upd_arg;
      rate_p0 <= bus.upd_rate;
      op_p0   <= bus.upd_op;
    end
  end

  // ---- stage 1 -> 2: bank writeback; a load to the same index overrides the update ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NW; i++) bank[i] <= INIT_VAL;
    end else begin
      if (wb_en) bank[idx_p0] <= res_s[Nbase-1:0];
      if (ld_ok) bank[bus.ld_idx] <= bus.ld_data;
    end
  end

  // Writeback status, saturation counter and registered read port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_p1     <= 1'b0;
      done_idx_p1 <= '0;
      sat_p1      <= 1'b0;
      sat_cnt_p1  <= '0;
      rd_p1       <= '0;
    end else begin
      done_p1 <= upd_ok;
      sat_p1  <= wb_sat;
      if (upd_ok) done_idx_p1 <= idx_p0;
      if (wb_sat && (sat_cnt_p1 != 16'hFFFF)) sat_cnt_p1 <= sat_cnt_p1 + 16'd1;
      rd_p1 <= rd_ok ? bank[bus.rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_nn_weight_update_seq.sv
// Directed bench for nn_weight_update_seq with NW=4, Nbase=8, Narg=16.
module tb_nn_weight_update_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] rv;

  nn_weight_update_seq_if #(.Nbase(8), .Narg(16), .IDXW(2)) bus ();

  nn_weight_update_seq #(
    .Nbase(8), .Narg(16), .NW(4), .IDXW(2), .INIT_VAL(8'd128)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_w(input int i, output logic [7:0] v);
    bus.rd_idx = 2'(i);
    tick();
    v = bus.rd_data;
  endtask

  task automatic req(input int idx, input int arg, input int rate, input logic op);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 2'(idx);
    bus.upd_arg   = 16'(arg);
    bus.upd_rate  = 8'(rate);
    bus.upd_op    = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.upd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0d want 0", bus.upd_ready); end
    vectors++;
    if (bus.rd_data !== 8'd0) begin miscompares++; $display("FAIL rst_rd_data got %0d want 0", bus.rd_data); end
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0d want 0", bus.upd_done); end
    vectors++;
    if (bus.sat_count !== 16'd0) begin miscompares++; $display("FAIL rst_sat_count got %0d want 0", bus.sat_count); end
    read_w(0, rv);
    vectors++;
    if (bus.upd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_rst got %0d want 1", bus.upd_ready); end
    vectors++;
    if (rv !== 8'd128) begin miscompares++; $display("FAIL rst_w0 got %0d want 128", rv); end
    for (int i = 1; i < 4; i++) begin
      read_w(i, rv);
      vectors++;
      if (rv !== 8'd128) begin miscompares++; $display("FAIL rst_w%0d got %0d want 128", i, rv); end
    end
  endtask

  task automatic test_scaled_add();
    req(1, 16'h0100, 4, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL add_done_early got %0d want 0", bus.upd_done); end
    tick();
    vectors++;
    if (bus.upd_done !== 1'b1) begin miscompares++; $display("FAIL add_done got %0d want 1", bus.upd_done); end
    vectors++;
    if (bus.upd_done_idx !== 2'd1) begin miscompares++; $display("FAIL add_done_idx got %0d want 1", bus.upd_done_idx); end
    vectors++;
    if (bus.upd_sat !== 1'b0) begin miscompares++; $display("FAIL add_sat got %0d want 0", bus.upd_sat); end
    tick();
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL add_done_pulse got %0d want 0", bus.upd_done); end
    read_w(1, rv);
    vectors++;
    if (rv !== 8'd144) begin miscompares++; $display("FAIL add_w1 got %0d want 144", rv); end
  endtask

  task automatic test_saturation();
    req(2, 16'h0FFF, 2, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    tick();
    vectors++;
    if (bus.upd_sat !== 1'b1) begin miscompares++; $display("FAIL sat_add_flag got %0d want 1", bus.upd_sat); end
    req(3, 200, 0, 1'b1);
    tick();
    bus.upd_valid = 1'b0;
    tick();
    vectors++;
    if (bus.upd_sat !== 1'b1) begin miscompares++; $display("FAIL sat_sub_flag got %0d want 1", bus.upd_sat); end
    vectors++;
    if (bus.upd_done_idx !== 2'd3) begin miscompares++; $display("FAIL sat_sub_idx got %0d want 3", bus.upd_done_idx); end
    tick();
    vectors++;
    if (bus.sat_count !== 16'd2) begin miscompares++; $display("FAIL sat_count got %0d want 2", bus.sat_count); end
    read_w(2, rv);
    vectors++;
    if (rv !== 8'd255) begin miscompares++; $display("FAIL sat_w2 got %0d want 255", rv); end
    read_w(3, rv);
    vectors++;
    if (rv !== 8'd0) begin miscompares++; $display("FAIL sat_w3 got %0d want 0", rv); end
  endtask

  task automatic test_back_to_back();
    req(0, 10, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (bus.upd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %0d want 1", c, bus.upd_ready); end
      tick();
      vectors++;
      if (bus.upd_done !== (c != 0)) begin miscompares++; $display("FAIL b2b_done[%0d] got %0d want %0d", c, bus.upd_done, (c != 0)); end
    end
    bus.upd_valid = 1'b0;
    tick();
    vectors++;
    if (bus.upd_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_last got %0d want 1", bus.upd_done); end
    tick();
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_end got %0d want 0", bus.upd_done); end
    read_w(0, rv);
    vectors++;
    if (rv !== 8'd168) begin miscompares++; $display("FAIL b2b_w0 got %0d want 168", rv); end
  endtask

  task automatic test_zero_scale();
    req(0, 16'hFFFF, 16, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    tick();
    vectors++;
    if (bus.upd_done !== 1'b1 || bus.upd_sat !== 1'b0) begin
      miscompares++; $display("FAIL zero_done_sat got %0d/%0d want 1/0", bus.upd_done, bus.upd_sat);
    end
    read_w(0, rv);
    vectors++;
    if (rv !== 8'd168) begin miscompares++; $display("FAIL zero_w0 got %0d want 168", rv); end
  endtask

  task automatic test_load_collision();
    req(1, 16'h0100, 4, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    bus.ld_en   = 1'b1;
    bus.ld_idx  = 2'd1;
    bus.ld_data = 8'd7;
    #1;
    vectors++;
    if (bus.upd_ready !== 1'b0) begin miscompares++; $display("FAIL ld_ready got %0d want 0", bus.upd_ready); end
    tick();
    bus.ld_en = 1'b0;
    vectors++;
    if (bus.upd_done !== 1'b1 || bus.upd_sat !== 1'b0) begin
      miscompares++; $display("FAIL ld_done_sat got %0d/%0d want 1/0", bus.upd_done, bus.upd_sat);
    end
    #1;
    vectors++;
    if (bus.upd_ready !== 1'b1) begin miscompares++; $display("FAIL ld_ready_back got %0d want 1", bus.upd_ready); end
    read_w(1, rv);
    vectors++;
    if (rv !== 8'd7) begin miscompares++; $display("FAIL ld_w1 got %0d want 7", rv); end
    // Update to idx 2 and load to idx 3 land on the same edge; both must take effect.
    req(2, 5, 0, 1'b1);
    tick();
    bus.upd_valid = 1'b0;
    bus.ld_en   = 1'b1;
    bus.ld_idx  = 2'd3;
    bus.ld_data = 8'd9;
    tick();
    bus.ld_en = 1'b0;
    vectors++;
    if (bus.upd_done_idx !== 2'd2) begin miscompares++; $display("FAIL ld_diff_idx got %0d want 2", bus.upd_done_idx); end
    read_w(2, rv);
    vectors++;
    if (rv !== 8'd250) begin miscompares++; $display("FAIL ld_diff_w2 got %0d want 250", rv); end
    read_w(3, rv);
    vectors++;
    if (rv !== 8'd9) begin miscompares++; $display("FAIL ld_diff_w3 got %0d want 9", rv); end
    vectors++;
    if (bus.sat_count !== 16'd2) begin miscompares++; $display("FAIL ld_sat_count got %0d want 2", bus.sat_count); end
  endtask

  task automatic test_reset_mid();
    req(0, 1, 0, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %0d want 0", bus.upd_done); end
    vectors++;
    if (bus.sat_count !== 16'd0) begin miscompares++; $display("FAIL mid_sat_count got %0d want 0", bus.sat_count); end
    tick();
    vectors++;
    if (bus.upd_done !== 1'b0) begin miscompares++; $display("FAIL mid_done_late got %0d want 0", bus.upd_done); end
    for (int i = 0; i < 4; i++) begin
      read_w(i, rv);
      vectors++;
      if (rv !== 8'd128) begin miscompares++; $display("FAIL mid_w%0d got %0d want 128", i, rv); end
    end
  endtask

  initial begin
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_arg   = '0;
    bus.upd_rate  = '0;
    bus.upd_op    = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_idx    = '0;
    bus.ld_data   = '0;
    bus.rd_idx    = '0;
    test_reset();
    test_scaled_add();
    test_saturation();
    test_back_to_back();
    test_zero_scale();
    test_load_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_weight_update_seq.md
Name: nn_weight_update_seq

Overview:
- Parametrised, pipelined successor to the single-value saturating add/subtract used for NN weight and bias updates.
- Holds a bank of NW unsigned weights of width Nbase. It accepts update requests through a valid/ready handshake, scales each request's argument by a per-request right-shift rate, and writes back a saturated sum or difference.
- Sits between the training/error-accumulation logic and the stochastic-number generators that read the weights.

Parameters:
- Nbase, 8: weight width (bits, unsigned).
- Narg, 16: update argument width (bits, unsigned).
- NW, 16: number of weights in the bank.
- IDXW, clog2(NW) (min 1): index width.
- INIT_VAL, 2^(Nbase-1): value loaded into every weight on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- upd_valid  in  1  update request present.
- upd_ready  out  1  block can accept a request this cycle.
- upd_idx  in  IDXW  target weight index.
- upd_arg  in  Narg  unscaled update magnitude.
- upd_rate  in  8  right-shift amount applied to upd_arg.
- upd_op  in  1  0 = add, 1 = subtract.
- ld_en  in  1  direct weight load strobe.
- ld_idx  in  IDXW  load index.
- ld_data  in  Nbase  load value.
- rd_idx  in  IDXW  read index.
- rd_data  out  Nbase  registered weight[rd_idx].
- upd_done  out  1  one-cycle pulse when a writeback occurs.
- upd_done_idx  out  IDXW  index written on the upd_done cycle.
- upd_sat  out  1  qualifies upd_done: that writeback was clamped.
- sat_count  out  16  total clamped writebacks, saturating counter.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Every weight is set to INIT_VAL.
  - rd_data = 0, upd_ready = 0, upd_done = 0, upd_done_idx = 0, upd_sat = 0, sat_count = 0.
  - The stage register valid bit is cleared, so any in-flight request is discarded with no writeback.
- upd_ready is a registered output: 1 on the first cycle after RST deasserts. Combinationally it is forced to 0 whenever ld_en = 1.
- A request is accepted at a rising edge where upd_valid & upd_ready = 1. Accepting it captures idx, arg, rate and op into the stage register.
- Stage 2 works combinationally from the stage register and the current bank contents. The weight is written at the next edge, so acceptance at edge k gives writeback at edge k+1.
- upd_done, upd_done_idx and upd_sat are registered together with the writeback; upd_done is high for the cycle after edge k+1.
- Throughput is one request per cycle. Back-to-back requests to the same index need no stall: request 2 reads the array after request 1's write has landed.
- Arithmetic:
  - scaled = upd_arg >> upd_rate, computed on the full Narg width; upd_rate >= Narg gives 0.
  - If scaled > 2^Nbase-1, scaled is clamped to 2^Nbase-1 and the writeback is flagged saturated.
  - Add: the sum is computed at Nbase+1 bits. A sum > 2^Nbase-1 writes 2^Nbase-1 and sets sat.
  - Subtract: scaled > w writes 0 and sets sat. scaled = w writes 0 with no sat.
  - scaled = 0 writes w unchanged (upd_done still pulses, sat = 0).
- sat_count increments by 1 on each writeback with sat = 1 and holds at 0xFFFF.
- Loads: ld_en writes ld_data to weight[ld_idx] at the edge.
  - A load and a stage-2 writeback to the same index at the same edge: the load wins, the update is dropped, and upd_done still pulses with upd_sat = 0.
  - A load and a writeback to different indices at the same edge: both take effect.
- rd_data <= weight[rd_idx] at every edge, using pre-edge contents. A write at edge k is therefore visible on rd_data after edge k+1.
- An index >= NW, on any port, is ignored: no write, and rd_data = 0.
- RST asserted mid-stream overrides everything above.

Test Plan (Nbase=8, Narg=16, NW=4, INIT_VAL=128):
- Reset then read: RST for 1 cycle, then rd_idx 0..3 -> rd_data = 128 each; upd_ready = 1 on the first cycle after reset; sat_count = 0.
- Scaled add: idx 1, arg 0x0100, rate 4, op 0 -> weight[1] = 128 + 16 = 144; upd_done pulses one cycle after acceptance with upd_done_idx = 1 and upd_sat = 0.
- Saturation both ways:
  - Add: idx 2, arg 0x0FFF, rate 2 (scaled 1023, clamped to 255) -> weight[2] = 255, upd_sat = 1.
  - Subtract: idx 3, arg 200, rate 0, op 1 -> weight[3] = 0, upd_sat = 1.
  - sat_count = 2 after both.
- Back-to-back same index: four consecutive cycles, each idx 0, arg 10, rate 0, op 0 -> weight[0] = 168; upd_done high for 4 consecutive cycles; upd_ready stays 1 throughout.
- Load collision: accept an update to idx 1 at edge k, and assert ld_en with ld_idx 1, ld_data 7 at edge k+1 -> weight[1] = 7; upd_ready = 0 while ld_en = 1.
- Reset mid-operation: accept an update at edge k and assert RST at edge k+1 -> all weights 128, no upd_done pulse, sat_count = 0.
